// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the accumulator ALU.
package alu_pkg;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b00100;
    localparam logic [4:0] OP_MOD = 5'b00101;
    localparam logic [4:0] OP_LSL = 5'b00110;
    localparam logic [4:0] OP_LSR = 5'b00111;
    localparam logic [4:0] OP_ROR = 5'b01000;
    localparam logic [4:0] OP_ROL = 5'b01001;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_XOR = 5'b01100;
    localparam logic [4:0] OP_NOT = 5'b01101;
    localparam logic [4:0] OP_CMP = 5'b01110;
    localparam logic [4:0] OP_TST = 5'b01111;
    localparam logic [4:0] OP_INC = 5'b10000;
    localparam logic [4:0] OP_DEC = 5'b10001;
    localparam logic [4:0] OP_MOV = 5'b10010;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// Shared W-bit adder/subtractor: carry_o is carry-out for add, borrow for subtract.
module alu_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o,
    output logic         ovf_o
);

    logic [W-1:0] b_eff;
    logic         cout;

    // Subtraction as A + ~B + 1; borrow is the inverted carry-out.
    assign b_eff            = sub_i ? ~b_i : b_i;
    assign {cout, sum_o}    = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
    assign carry_o          = cout ^ sub_i;
    assign ovf_o            = (a_i[W-1] == b_eff[W-1]) && (sum_o[W-1] != a_i[W-1]);

endmodule

// File: rtl/alu_core.sv
// Registered signed integer ALU: one operation per clock, result and {Z,N,C,V} flags registered.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);

    localparam int SHW = $clog2(W);
    localparam logic [SHW:0] W_EXT = W[SHW:0];

    logic [W-1:0] result_q, result_d;
    logic [3:0]   flags_q, flags_d;

    // Shared adder inputs
    logic [W-1:0] as_b, as_sum;
    logic         as_sub, as_carry, as_ovf;

    always_comb begin
        as_sub = 1'b0;
        as_b   = operandB;
        case (alu_op)
            OP_SUB, OP_CMP: as_sub = 1'b1;
            OP_INC:         as_b   = {{(W-1){1'b0}}, 1'b1};
            OP_DEC: begin
                as_sub = 1'b1;
                as_b   = {{(W-1){1'b0}}, 1'b1};
            end
            default: ;
        endcase
    end

    alu_addsub #(.W(W)) u_addsub (
        .a_i     (operandA),
        .b_i     (as_b),
        .sub_i   (as_sub),
        .sum_o   (as_sum),
        .carry_o (as_carry),
        .ovf_o   (as_ovf)
    );

    // Multiply: overflow when the upper half is not a sign extension of the low half.
    logic signed [2*W-1:0] product;
    logic                  mul_ovf;
    assign product = $signed({{W{operandA[W-1]}}, operandA}) * $signed({{W{operandB[W-1]}}, operandB});
    assign mul_ovf = product[2*W-1:W] != {W{product[W-1]}};

    // Divide: the divisor is forced to 1 for B==0 and MIN/-1 so the divider never traps;
    // MIN/1 yields quotient MIN and remainder 0, which is exactly the required MIN/-1 answer.
    logic signed [W-1:0] a_s, b_safe, quot, rem;
    logic                b_zero, div_ovf;
    assign b_zero  = (operandB == '0);
    assign div_ovf = (operandA == {1'b1, {(W-1){1'b0}}}) && (operandB == '1);
    assign a_s     = operandA;
    assign b_safe  = (b_zero || div_ovf) ? {{(W-1){1'b0}}, 1'b1} : operandB;
    assign quot    = a_s / b_safe;
    assign rem     = a_s % b_safe;

    // Shifts keep one extra bit to capture the last bit shifted out.
    logic [SHW-1:0] amt, rot_amt;
    logic [SHW:0]   rot_inv;
    logic [W:0]     lsl_ext, lsr_ext;
    logic [W-1:0]   ror_res, rol_res;
    assign amt     = operandB[SHW-1:0];
    assign lsl_ext = {1'b0, operandA} << amt;
    assign lsr_ext = {operandA, 1'b0} >> amt;
    assign rot_amt = ({1'b0, amt} >= W_EXT) ? (amt - W_EXT[SHW-1:0]) : amt;
    assign rot_inv = W_EXT - {1'b0, rot_amt};
    assign ror_res = (operandA >> rot_amt) | (operandA << rot_inv);
    assign rol_res = (operandA << rot_amt) | (operandA >> rot_inv);

    logic [W-1:0] value;
    logic         c_bit, v_bit, upd_result, upd_flags, amt_nz;
    assign amt_nz = (amt != '0);

    always_comb begin
        value      = '0;
        c_bit      = 1'b0;
        v_bit      = 1'b0;
        upd_result = 1'b1;
        upd_flags  = 1'b1;
        case (alu_op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                value = as_sum;
                c_bit = as_carry;
                v_bit = as_ovf;
            end
            OP_CMP: begin
                value      = as_sum;
                c_bit      = as_carry;
                v_bit      = as_ovf;
                upd_result = 1'b0;
            end
            OP_MUL: begin
                value = product[W-1:0];
                v_bit = mul_ovf;
            end
            OP_DIV: begin
                value = b_zero ? '0 : quot;
                v_bit = b_zero | div_ovf;
            end
            OP_MOD: begin
                value = b_zero ? '0 : rem;
                v_bit = b_zero;
            end
            OP_LSL: begin
                value = lsl_ext[W-1:0];
                c_bit = amt_nz & lsl_ext[W];
            end
            OP_LSR: begin
                value = lsr_ext[W:1];
                c_bit = amt_nz & lsr_ext[0];
            end
            OP_ROR: begin
                value = ror_res;
                c_bit = amt_nz & ror_res[W-1];
            end
            OP_ROL: begin
                value = rol_res;
                c_bit = amt_nz & rol_res[0];
            end
            OP_AND: value = operandA & operandB;
            OP_OR:  value = operandA | operandB;
            OP_XOR: value = operandA ^ operandB;
            OP_NOT: value = ~operandA;
            OP_TST: begin
                value      = operandA & operandB;
                upd_result = 1'b0;
            end
            OP_MOV: value = operandB;
            default: begin
                upd_result = 1'b0;
                upd_flags  = 1'b0;
            end
        endcase
    end

    always_comb begin
        result_d = upd_result ? value : result_q;
        flags_d  = flags_q;
        if (upd_flags) begin
            flags_d[FLAG_Z] = (value == '0);
            flags_d[FLAG_N] = value[W-1];
            flags_d[FLAG_C] = c_bit;
            flags_d[FLAG_V] = v_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign resultAccumulator = result_q;
    assign flags             = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core (W=16): expected results queued at drive time, popped after each edge.
module tb_alu_core;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  alu_op;
    logic [15:0] operandA;
    logic [15:0] operandB;
    logic [15:0] resultAccumulator;
    logic [3:0]  flags;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    alu_core #(.W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alu_op            (alu_op),
        .operandA          (operandA),
        .operandB          (operandB),
        .resultAccumulator (resultAccumulator),
        .flags             (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_now(string tag, logic [15:0] er, logic [3:0] ef);
        tests_run++;
        assert (resultAccumulator === er) else begin
            tests_failed++;
            $error("FAIL %s result: got %h expected %h", tag, resultAccumulator, er);
        end
        tests_run++;
        assert (flags === ef) else begin
            tests_failed++;
            $error("FAIL %s flags: got %b expected %b", tag, flags, ef);
        end
    endtask

    task automatic do_op(string tag, logic [4:0] op, logic [15:0] a, logic [15:0] b,
                         logic [15:0] er, logic [3:0] ef);
        exp_t e;
        alu_op   = op;
        operandA = a;
        operandB = b;
        sb.push_back('{tag, er, ef});
        @(posedge clk);
        #1;
        tests_run++;
        assert (sb.size() != 0) else begin
            tests_failed++;
            $error("FAIL %s scoreboard: got empty queue expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_now(e.tag, e.res, e.flg);
            $display("[TB] %-10s op=%b A=%h B=%h -> res=%h flags=%b", tag, op, a, b,
                     resultAccumulator, flags);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        alu_op   = OP_NOP;
        operandA = '0;
        operandB = '0;
        #2;
        check_now("reset_init", 16'h0000, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Asynchronous reset with a non-zero result held
        do_op("mov_1234", OP_MOV, 16'h0000, 16'h1234, 16'h1234, 4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        check_now("async_rst", 16'h0000, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op("add_3_4",  OP_ADD, 16'd3, 16'd4, 16'h0007, 4'b0000);

        // CMP leaves result alone
        do_op("mov_55",   OP_MOV, 16'h0000, 16'h0055, 16'h0055, 4'b0000);
        do_op("cmp1",     OP_CMP, 16'hFFE0, 16'h0005, 16'h0055, 4'b0100);
        do_op("cmp2",     OP_CMP, 16'hFFF3, 16'hFFFD, 16'h0055, 4'b0110);
        do_op("cmp3",     OP_CMP, 16'h0009, 16'hFFFF, 16'h0055, 4'b0010);
        do_op("cmp4",     OP_CMP, 16'h0010, 16'h000B, 16'h0055, 4'b0000);
        do_op("cmp5",     OP_CMP, 16'h0007, 16'h0007, 16'h0055, 4'b1000);

        // Overflow and carry
        do_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        do_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
        do_op("add_cz",   OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);

        // Shifts and rotates
        do_op("lsl_1",    OP_LSL, 16'h8001, 16'h0001, 16'h0002, 4'b0010);
        do_op("ror_1",    OP_ROR, 16'h0001, 16'h0001, 16'h8000, 4'b0110);
        do_op("lsr_0",    OP_LSR, 16'h00F1, 16'h0000, 16'h00F1, 4'b0000);
        do_op("rol_1",    OP_ROL, 16'h8000, 16'h0001, 16'h0001, 4'b0010);
        do_op("lsr_1",    OP_LSR, 16'h0003, 16'h0001, 16'h0001, 4'b0010);
        do_op("lsl_nc",   OP_LSL, 16'h4000, 16'h0001, 16'h8000, 4'b0100);
        do_op("ror_4",    OP_ROR, 16'h1234, 16'h0004, 16'h4123, 4'b0000);

        // Divide and remainder
        do_op("div_m7_2", OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 4'b0100);
        do_op("mod_m7_2", OP_MOD, 16'hFFF9, 16'h0002, 16'hFFFF, 4'b0100);
        do_op("mod_7_m2", OP_MOD, 16'h0007, 16'hFFFE, 16'h0001, 4'b0000);
        do_op("div_min",  OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 4'b0101);
        do_op("div_5_0",  OP_DIV, 16'h0005, 16'h0000, 16'h0000, 4'b1001);

        // NOP and reserved opcodes hold everything
        do_op("nop1",     OP_NOP,   16'hAAAA, 16'h5555, 16'h0000, 4'b1001);
        do_op("nop2",     OP_NOP,   16'h1111, 16'h2222, 16'h0000, 4'b1001);
        do_op("nop3",     OP_NOP,   16'hFFFF, 16'hFFFF, 16'h0000, 4'b1001);
        do_op("rsv1",     5'b11111, 16'h1234, 16'h0001, 16'h0000, 4'b1001);
        do_op("rsv2",     5'b11111, 16'h8000, 16'h8000, 16'h0000, 4'b1001);
        do_op("rsv3",     5'b10011, 16'h7FFF, 16'h0001, 16'h0000, 4'b1001);

        // Multiply, inc/dec, logic, test, move
        do_op("mul_neg",  OP_MUL, 16'h0003, 16'hFFFC, 16'hFFF4, 4'b0100);
        do_op("mul_ovf",  OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1001);
        do_op("inc_ovf",  OP_INC, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101);
        do_op("dec_0",    OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110);
        do_op("and",      OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
        do_op("or",       OP_OR,  16'hF000, 16'h000F, 16'hF00F, 4'b0100);
        do_op("xor",      OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000);
        do_op("not",      OP_NOT, 16'h0000, 16'h1234, 16'hFFFF, 4'b0100);
        do_op("tst_n",    OP_TST, 16'h8000, 16'hFFFF, 16'hFFFF, 4'b0100);
        do_op("tst_z",    OP_TST, 16'h000F, 16'h00F0, 16'hFFFF, 4'b1000);
        do_op("mov_0",    OP_MOV, 16'h1234, 16'h0000, 16'h0000, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
Registered, parameterised signed integer ALU for the accumulator datapath.
- Each rising clock edge it decodes a 5-bit opcode, computes on operandA/operandB and updates the result and the 4-bit status flags.
- The result and flags feed the control unit: branch conditions and compare outcomes come from the flags.
- CMP only updates the flags and leaves the result untouched.

Parameters:
- W, 16, data width in bits (two's complement); minimum 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_op  in  5  operation select.
- operandA  in  W  signed first operand.
- operandB  in  W  signed second operand; also the shift amount.
- resultAccumulator  out  W  registered signed result.
- flags  out  4  registered status, {Z,N,C,V}: flags[3]=Z, flags[2]=N, flags[1]=C, flags[0]=V.

Behaviour:
- Reset: rst_n low forces resultAccumulator=0 and flags=4'b0000 immediately. Release takes effect on the next rising edge. Reset asserted mid-operation discards that operation.
- Latency: inputs are sampled on a rising edge and outputs are valid after that same edge (1 cycle). There is no handshake; a new operation can start every cycle.
- Z = (value==0) and N = MSB of the value, where the value is the computed result, or the A-B difference for CMP.
- Opcodes, with flag rules:
  - 00000 NOP: hold result and flags.
  - 00001 ADD: A+B. C = unsigned carry-out; V = signed overflow.
  - 00010 SUB: A-B. C = borrow (unsigned A < unsigned B); V = signed overflow.
  - 00011 MUL: low W bits of the signed product. C=0; V=1 if the full product is not representable in W signed bits.
  - 00100 DIV: signed quotient, truncated toward zero.
  - 00101 MOD: signed remainder, with the sign of A.
    - DIV/MOD with B==0: result=0, V=1, C=0, Z=1, N=0.
    - DIV with A=min and B=-1: result=min, V=1.
  - 00110 LSL: logical shift left. 00111 LSR: logical shift right.
  - 01000 ROR: rotate right. 01001 ROL: rotate left.
    - Shift/rotate amount = B[$clog2(W)-1:0].
    - C = last bit shifted or rotated out; C=0 when the amount is 0. V=0.
  - 01010 AND, 01011 OR, 01100 XOR, 01101 NOT(A): C=0, V=0.
  - 01110 CMP: compute A-B. Set Z,N,C,V exactly as SUB; result holds.
  - 01111 TST: compute A&B. Set Z,N; C=0, V=0; result holds.
  - 10000 INC: A+1. 10001 DEC: A-1. Flags as ADD/SUB with B=1.
  - 10010 MOV: result=B. Z,N from B; C=0, V=0.
  - 10011..11111 reserved: behave as NOP.
- All arithmetic wraps modulo 2^W.
- Combinational next-state logic must have no latches; only the two output registers hold state.

Decomposition:
- Package alu_pkg: opcode localparams (OP_NOP..OP_MOV), flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0).
- One sub-module, alu_addsub: a shared W-bit adder/subtractor producing sum, carry/borrow and overflow. It is used by ADD, SUB, CMP, INC and DEC.

Test Plan:
- Reset: drive rst_n low asynchronously while result=0x1234 -> result=0 and flags=0000 without waiting for a clock edge. After release, ADD 3+4 -> result=7, flags=0000.
- CMP sequence (W=16), with result preloaded to 0x0055 and unchanged throughout:
  - A=-32, B=5 -> 0100
  - A=-13, B=-3 -> 0110
  - A=9, B=-1 -> 0010
  - A=16, B=11 -> 0000
  - A=7, B=7 -> 1000
- Overflow and carry:
  - ADD 32767+1 -> result=-32768, flags=0101.
  - SUB -32768-1 -> result=32767, flags=0001.
  - ADD -1+1 -> result=0, flags=1010.
- Shifts (W=16):
  - LSL 0x8001 by 1 -> 0x0002, C=1.
  - ROR 0x0001 by 1 -> 0x8000, N=1, C=1.
  - LSR by 0 -> unchanged, C=0.
- Divide:
  - DIV -7/2 -> -3.
  - MOD -7/2 -> -1.
  - DIV 5/0 -> result 0, flags=1001.
- Reserved opcode 11111 and NOP -> result and flags unchanged over 3 cycles. Back-to-back ops on consecutive cycles each appear after exactly one edge.
